// File: rtl/video_out_load_if.sv
// rtl/video_out_load_if.sv - Wishbone read-master bus bundle for the video-out frame loader
interface video_out_load_if;
    logic        p_wb_STB_O;
    logic        p_wb_CYC_O;
    logic        p_wb_LOCK_O;
    logic [3:0]  p_wb_SEL_O;
    logic        p_wb_WE_O;
    logic [31:0] p_wb_ADR_O;
    logic [31:0] p_wb_DAT_I;
    logic        p_wb_ACK_I;
    logic        p_wb_ERR_I;

    modport master (
        output p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_SEL_O, p_wb_WE_O, p_wb_ADR_O,
        input  p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I
    );

    modport slave (
        input  p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_SEL_O, p_wb_WE_O, p_wb_ADR_O,
        output p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I
    );
endinterface

// File: rtl/video_out_load.sv
// rtl/video_out_load.sv - Wishbone master reading a frame from RAM in packs into the video-out FIFO
module video_out_load #(
    parameter int p_WIDTH  = 640,
    parameter int p_HEIGHT = 480,
    parameter int NB_PACK  = 16
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] wb_reg_ctr,
    input  logic [31:0] wb_reg_data,
    input  logic        fifo_room,
    output logic        w_en,
    output logic [31:0] data_fifo,
    output logic        interrupt,
    output logic        error,
    video_out_load_if.master wb
);
    localparam int          PCW         = $clog2(NB_PACK + 1);
    localparam logic [19:0] FRAME_BYTES = 20'(p_WIDTH * p_HEIGHT);

    typedef enum logic [2:0] {WAIT_ADDR, WAIT_ROOM, REQ, WAIT_ACK, FRAME_DONE} state_t;

    state_t           state;
    logic [31:0]      base;
    logic [19:0]      offset;
    logic [PCW-1:0]   pack_cnt;
    logic [1:0]       int_cnt;
    logic             old_ctr0;
    logic             new_addr;
    logic [19:0]      offset_nxt;
    logic             unused_ctr;

    assign new_addr   = ~old_ctr0 & wb_reg_ctr[0];
    assign offset_nxt = offset + 20'd4;
    assign unused_ctr = ^wb_reg_ctr[31:1];

    assign wb.p_wb_LOCK_O = 1'b0;
    assign wb.p_wb_SEL_O  = 4'hf;
    assign wb.p_wb_WE_O   = 1'b0;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state         <= WAIT_ADDR;
            base          <= '0;
            offset        <= '0;
            pack_cnt      <= '0;
            int_cnt       <= '0;
            old_ctr0      <= 1'b1;
            w_en          <= 1'b0;
            data_fifo     <= '0;
            interrupt     <= 1'b0;
            error         <= 1'b0;
            wb.p_wb_STB_O <= 1'b0;
            wb.p_wb_CYC_O <= 1'b0;
            wb.p_wb_ADR_O <= '0;
        end else begin
            old_ctr0 <= wb_reg_ctr[0];
            w_en     <= 1'b0;
            case (state)
                WAIT_ADDR: begin
                    if (new_addr) begin
                        base   <= wb_reg_data;
                        offset <= '0;
                        error  <= 1'b0;
                        state  <= WAIT_ROOM;
                    end
                end
                WAIT_ROOM: begin
                    if (fifo_room) begin
                        pack_cnt <= PCW'(NB_PACK);
                        state    <= REQ;
                    end
                end
                REQ: begin
                    wb.p_wb_CYC_O <= 1'b1;
                    wb.p_wb_STB_O <= 1'b1;
                    wb.p_wb_ADR_O <= base + {12'd0, offset};
                    state         <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (wb.p_wb_ACK_I || wb.p_wb_ERR_I) begin
                        wb.p_wb_STB_O <= 1'b0;
                        w_en          <= 1'b1;
                        // An errored word still goes to the FIFO as zero so pixels stay aligned
                        if (wb.p_wb_ERR_I) begin
                            data_fifo <= '0;
                            error     <= 1'b1;
                        end else begin
                            data_fifo <= wb.p_wb_DAT_I;
                        end
                        offset   <= offset_nxt;
                        pack_cnt <= pack_cnt - PCW'(1);
                        if (offset_nxt == FRAME_BYTES) begin
                            wb.p_wb_CYC_O <= 1'b0;
                            int_cnt       <= '0;
                            state         <= FRAME_DONE;
                        end else if (pack_cnt == PCW'(1)) begin
                            wb.p_wb_CYC_O <= 1'b0;
                            state         <= WAIT_ROOM;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                FRAME_DONE: begin
                    if (int_cnt == 2'd3) begin
                        interrupt <= 1'b0;
                        state     <= WAIT_ADDR;
                    end else begin
                        interrupt <= 1'b1;
                        int_cnt   <= int_cnt + 2'd1;
                    end
                end
                default: state <= WAIT_ADDR;
            endcase
        end
    end
endmodule

// File: tb/tb_video_out_load.sv
// tb/tb_video_out_load.sv - directed bench for video_out_load with a Wishbone RAM slave model
module tb_video_out_load;
    localparam int W  = 8;
    localparam int H  = 2;
    localparam int NP = 2;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] wb_reg_ctr;
    logic [31:0] wb_reg_data;
    logic        fifo_room;
    logic        w_en;
    logic [31:0] data_fifo;
    logic        interrupt;
    logic        error;

    video_out_load_if bus();

    video_out_load #(.p_WIDTH(W), .p_HEIGHT(H), .NB_PACK(NP)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .wb_reg_ctr (wb_reg_ctr),
        .wb_reg_data(wb_reg_data),
        .fifo_room  (fifo_room),
        .w_en       (w_en),
        .data_fifo  (data_fifo),
        .interrupt  (interrupt),
        .error      (error),
        .wb         (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // RAM slave: acknowledges one cycle after STB, data = 0xA0 + word index in frame
    logic [31:0] cur_base = 32'h0;
    int          ack_delay = 1;
    int          err_idx   = -1;
    int          wcnt      = 0;
    logic [31:0] idx;

    always @(negedge clk) begin
        if (bus.p_wb_STB_O && !bus.p_wb_ACK_I && !bus.p_wb_ERR_I) begin
            if (wcnt >= ack_delay) begin
                idx = (bus.p_wb_ADR_O - cur_base) >> 2;
                if (idx == 32'(err_idx)) begin
                    bus.p_wb_ERR_I = 1'b1;
                end else begin
                    bus.p_wb_ACK_I = 1'b1;
                    bus.p_wb_DAT_I = 32'hA0 + idx;
                end
            end else begin
                wcnt++;
            end
        end else begin
            bus.p_wb_ACK_I = 1'b0;
            bus.p_wb_ERR_I = 1'b0;
            wcnt = 0;
        end
    end

    logic [31:0] adr_q[$];
    logic [31:0] dat_q[$];
    int          gap_q[$];
    int          cyc_low = 0;
    int          irq_cnt = 0;
    int          stb_cnt = 0;
    logic        stb_d   = 1'b0;

    always @(negedge clk) begin
        if (bus.p_wb_STB_O && !stb_d) begin
            adr_q.push_back(bus.p_wb_ADR_O);
            gap_q.push_back(cyc_low);
            check("we_low", {31'd0, bus.p_wb_WE_O}, 32'd0);
            cyc_low = 0;
        end
        if (!bus.p_wb_CYC_O) cyc_low++;
        if (bus.p_wb_STB_O) stb_cnt++;
        stb_d = bus.p_wb_STB_O;
        if (w_en) dat_q.push_back(data_fifo);
        if (interrupt) irq_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        adr_q.delete();
        dat_q.delete();
        gap_q.delete();
        irq_cnt = 0;
        cyc_low = 0;
    endtask

    task automatic start_frame(input logic [31:0] b);
        wb_reg_data = b;
        wb_reg_ctr  = 32'd0;
        cycles(2);
        wb_reg_ctr  = 32'd1;
    endtask

    task automatic wait_adrs(input int n, input string tag);
        int t = 0;
        while (adr_q.size() < n && t < 300) begin @(negedge clk); t++; end
        check(tag, {31'd0, adr_q.size() >= n}, 32'd1);
    endtask

    task automatic wait_words(input int n, input string tag);
        int t = 0;
        while (dat_q.size() < n && t < 300) begin @(negedge clk); t++; end
        check(tag, {31'd0, dat_q.size() >= n}, 32'd1);
    endtask

    task automatic wait_frame(input string tag);
        int t = 0;
        while (!(irq_cnt > 0 && !interrupt) && t < 400) begin @(negedge clk); t++; end
        check(tag, {31'd0, irq_cnt > 0 && !interrupt}, 32'd1);
    endtask

    task automatic check_frame(input string tg, input logic [31:0] b, input int e_idx);
        logic [31:0] ea;
        check({tg, "_nadr"}, adr_q.size(), 32'd4);
        check({tg, "_ndat"}, dat_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            ea = b + 32'(4 * i);
            check($sformatf("%s_adr%0d", tg, i), adr_q[i], ea);
            check($sformatf("%s_dat%0d", tg, i), dat_q[i], (i == e_idx) ? 32'd0 : 32'hA0 + 32'(i));
        end
        check({tg, "_irq3"}, irq_cnt, 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fifo_room      = 1'b1;
        wb_reg_ctr     = 32'd1;
        wb_reg_data    = 32'd0;
        bus.p_wb_DAT_I = 32'd0;
        bus.p_wb_ACK_I = 1'b0;
        bus.p_wb_ERR_I = 1'b0;
        cycles(3);
        check("rst_stb", {31'd0, bus.p_wb_STB_O}, 32'd0);
        check("rst_cyc", {31'd0, bus.p_wb_CYC_O}, 32'd0);
        check("rst_sel", {28'd0, bus.p_wb_SEL_O}, 32'hf);
        check("rst_adr", bus.p_wb_ADR_O, 32'd0);
        check("rst_outs", {28'd0, w_en, interrupt, error, bus.p_wb_LOCK_O}, 32'd0);
        check("rst_data", data_fifo, 32'd0);
        nRST = 1'b1;
        cycles(8);
        check("held_ctr_no_start", adr_q.size(), 32'd0);

        // nominal frame
        clear_log();
        cur_base = 32'h1000;
        start_frame(32'h1000);
        wait_frame("nom_done");
        check_frame("nom", 32'h1000, -1);
        check("nom_cyc_in_pack", gap_q[1], 32'd0);
        check("nom_cyc_drop", {31'd0, gap_q[2] > 0}, 32'd1);
        cycles(10);
        check("nom_idle", adr_q.size(), 32'd4);

        // backpressure between packs
        clear_log();
        start_frame(32'h1000);
        wait_adrs(1, "bp_first");
        fifo_room = 1'b0;
        wait_words(2, "bp_pack1");
        stb_cnt = 0;
        cycles(10);
        check("bp_no_stb", stb_cnt, 32'd0);
        check("bp_nadr_held", adr_q.size(), 32'd2);
        fifo_room = 1'b1;
        wait_frame("bp_done");
        check_frame("bp", 32'h1000, -1);

        // bus error on second access
        clear_log();
        err_idx = 1;
        start_frame(32'h1000);
        wait_frame("err_done");
        check_frame("err", 32'h1000, 1);
        check("err_sticky", {31'd0, error}, 32'd1);
        err_idx = -1;

        // control edge mid-frame is ignored
        clear_log();
        start_frame(32'h1000);
        cycles(2);
        check("err_cleared", {31'd0, error}, 32'd0);
        wait_adrs(1, "ign_first");
        wb_reg_data = 32'h2000;
        wb_reg_ctr  = 32'd0;
        cycles(2);
        wb_reg_ctr  = 32'd1;
        wait_frame("ign_done");
        check_frame("ign", 32'h1000, -1);
        cycles(10);
        check("ign_no_restart", adr_q.size(), 32'd4);

        // asynchronous reset mid-pack
        clear_log();
        start_frame(32'h1000);
        wait_adrs(1, "rst_first");
        #2 nRST = 1'b0;
        #1;
        check("arst_stb", {31'd0, bus.p_wb_STB_O}, 32'd0);
        check("arst_cyc", {31'd0, bus.p_wb_CYC_O}, 32'd0);
        check("arst_wen_irq", {30'd0, w_en, interrupt}, 32'd0);
        cycles(2);
        nRST = 1'b1;
        clear_log();
        cycles(20);
        check("arst_no_start", adr_q.size(), 32'd0);

        // address wrap
        clear_log();
        cur_base = 32'hFFFF_FFF8;
        start_frame(32'hFFFF_FFF8);
        wait_frame("wrap_done");
        check_frame("wrap", 32'hFFFF_FFF8, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
